// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding one shared output register over a valid/ready
// handshake, with optional per-requester lock for back-to-back ownership.
module rr_reg_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [WIDTH-1:0]         out,
    output logic [IDX_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic             owner_valid;
    logic [IDX_W-1:0] win;
    logic [IDX_W:0]   scan;
    logic             found;
    logic             can_accept;
    logic             xfer;
    logic             deliver;

    assign out_valid  = (state == FULL);
    assign can_accept = !out_valid || out_ready;
    assign xfer       = |(req & grant);
    assign deliver    = out_valid && out_ready;

    // A held lock restricts the grant to the owner, even when the owner is idle.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        scan  = '0;
        if (!reset && can_accept) begin
            if (owner_valid) begin
                win          = owner;
                grant[owner] = req[owner];
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    scan = {1'b0, ptr} + (IDX_W+1)'(k);
                    if (scan >= (IDX_W+1)'(NUM_REQ)) begin
                        scan = scan - (IDX_W+1)'(NUM_REQ);
                    end
                    if (!found && req[scan[IDX_W-1:0]]) begin
                        found = 1'b1;
                        win   = scan[IDX_W-1:0];
                    end
                end
                if (found) begin
                    grant[win] = 1'b1;
                end
            end
        end
    end

    // A new transfer wins over a same-edge delivery, keeping the register full.
    always_comb begin
        state_next = state;
        if (xfer) begin
            state_next = FULL;
        end else if (deliver) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out         <= '0;
            out_src     <= '0;
            ptr         <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
        end else if (xfer) begin
            out         <= data[int'(win)*WIDTH +: WIDTH];
            out_src     <= win;
            ptr         <= (win == IDX_W'(NUM_REQ-1)) ? '0 : win + IDX_W'(1);
            owner       <= win;
            owner_valid <= lock[win];
        end else if (owner_valid && !req[owner]) begin
            owner_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter: directed grant vectors push expected
// beats, and a monitor checks each delivered beat against the queue.
module tb_rr_reg_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [1:0]       s;
    } beat_t;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       lock;
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0]       grant;
    logic [WIDTH-1:0]         out;
    logic [1:0]               out_src;
    logic                     out_valid;
    logic                     out_ready;

    logic [WIDTH-1:0] dval [NUM_REQ];
    beat_t            sb [$];
    int               checks;
    int               passes;
    bit               done;

    rr_reg_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .data      (data),
        .grant     (grant),
        .out       (out),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data[i*WIDTH +: WIDTH] = dval[i];
        end
    end

    task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                                input logic [WIDTH-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check the grant, and
    // record the beat that the next rising edge should capture.
    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] l,
                                  input logic rdy, input logic [3:0] exp_g);
        beat_t b;
        @(negedge clk);
        req       = r;
        lock      = l;
        out_ready = rdy;
        #1;
        check_output("grant", WIDTH'(grant), WIDTH'(exp_g));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_g[i]) begin
                b.d = dval[i];
                b.s = 2'(i);
                sb.push_back(b);
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] r, input logic rdy);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset     = 1'b1;
            req       = r;
            lock      = '0;
            out_ready = rdy;
            #1;
            check_output("grant_in_reset", WIDTH'(grant), '0);
            sb.delete();
        end
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        #1;
        check_output("rst_out_valid", WIDTH'(out_valid), '0);
        check_output("rst_out", out, '0);
        check_output("rst_out_src", WIDTH'(out_src), '0);
    endtask

    // Monitor: every delivered beat must match the oldest expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!done && !reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_beat: got out=%0h src=%0d, expected no beat", out, out_src);
                end else begin
                    e = sb.pop_front();
                    check_output("beat_data", out, e.d);
                    check_output("beat_src", WIDTH'(out_src), WIDTH'(e.s));
                end
            end
        end
    end

    initial begin
        checks    = 0;
        passes    = 0;
        done      = 1'b0;
        reset     = 1'b1;
        req       = '0;
        lock      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) dval[i] = 32'hA0 + i;

        do_reset(4'b1111, 1'b1);
        // Two requesters alternate from a fresh pointer.
        apply_stimulus(4'b0101, 4'b0000, 1'b1, 4'b0001);
        apply_stimulus(4'b0101, 4'b0000, 1'b1, 4'b0100);
        apply_stimulus(4'b0101, 4'b0000, 1'b1, 4'b0001);
        apply_stimulus(4'b0101, 4'b0000, 1'b1, 4'b0100);
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

        do_reset(4'b0000, 1'b1);
        for (int i = 0; i < NUM_REQ; i++) dval[i] = 32'h10 + i;
        apply_stimulus(4'b1111, 4'b0000, 1'b1, 4'b0001);
        apply_stimulus(4'b1111, 4'b0000, 1'b1, 4'b0010);
        apply_stimulus(4'b1111, 4'b0000, 1'b1, 4'b0100);
        apply_stimulus(4'b1111, 4'b0000, 1'b1, 4'b1000);
        apply_stimulus(4'b1111, 4'b0000, 1'b1, 4'b0001);
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Backpressure: ptr=1, beat from requester 1 held while req[2] waits.
        dval[1] = 32'hAA;
        dval[2] = 32'hBB;
        apply_stimulus(4'b0010, 4'b0000, 1'b1, 4'b0010);
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(4'b0100, 4'b0000, 1'b0, 4'b0000);
            check_output("hold_out", out, 32'hAA);
            check_output("hold_valid", WIDTH'(out_valid), 1);
        end
        apply_stimulus(4'b0100, 4'b0000, 1'b1, 4'b0100);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 4'b0000);
        check_output("full_to_full_valid", WIDTH'(out_valid), 1);
        check_output("full_to_full_out", out, 32'hBB);
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Lock: ptr=3, requester 3 keeps ownership until it drops lock.
        dval[3] = 32'hC3;
        dval[0] = 32'hC0;
        apply_stimulus(4'b1001, 4'b1000, 1'b1, 4'b1000);
        apply_stimulus(4'b1001, 4'b1000, 1'b1, 4'b1000);
        apply_stimulus(4'b1001, 4'b0000, 1'b1, 4'b1000);
        apply_stimulus(4'b0001, 4'b0000, 1'b1, 4'b0001);
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Owner 1 drops req: one dead cycle, then requester 2 wins and locks.
        dval[1] = 32'hD1;
        dval[2] = 32'hD2;
        apply_stimulus(4'b0010, 4'b0010, 1'b1, 4'b0010);
        apply_stimulus(4'b0100, 4'b0000, 1'b1, 4'b0000);
        apply_stimulus(4'b0100, 4'b0100, 1'b1, 4'b0100);

        // Reset while full and locked discards the beat and the lock.
        do_reset(4'b1111, 1'b0);
        apply_stimulus(4'b1111, 4'b0000, 1'b1, 4'b0001);
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
        check_output("final_valid", WIDTH'(out_valid), 0);
        check_output("sb_drained", WIDTH'(sb.size()), 0);
        done = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin arbiter that shares a single WIDTH-bit output register among NUM_REQ requesters. Each cycle it grants at most one requester, captures that requester's data into the shared register, and presents it downstream on a valid/ready handshake. Optional per-requester lock keeps ownership across back-to-back beats. Sits in front of shared datapath resources that accept one operand stream at a time.

## Interface
- WIDTH, 32, data width of each requester and of the shared register
- NUM_REQ, 4, number of requesters, legal range 2..16; IDX_W = $clog2(NUM_REQ)

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request; bit i belongs to requester i
- lock  input  NUM_REQ  per-requester lock; sampled only on a transfer
- data  input  NUM_REQ*WIDTH  flattened requester data; requester i owns bits [i*WIDTH +: WIDTH]
- grant  output  NUM_REQ  one-hot or zero; a transfer occurs on the clk edge where req[i] & grant[i]
- out  output  WIDTH  shared register contents
- out_src  output  IDX_W  index of the requester whose data is in out
- out_valid  output  1  out holds an undelivered beat
- out_ready  input  1  downstream accepts; a beat is delivered on an edge where out_valid & out_ready

## Operation
- Storage: one data register (out), one source register (out_src), one valid flag, one round-robin pointer ptr (IDX_W bits), one owner register with owner_valid flag.
- Two states, derived from out_valid:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- can_accept = !out_valid | out_ready. Grants are issued only when can_accept=1.
- Unlocked arbitration: the first index i with req[i]=1, scanning ptr, ptr+1, ... and wrapping mod NUM_REQ, receives grant[i]=1. No request means grant=0.
- Locked arbitration: while owner_valid=1, only the owner can be granted. Other requests are ignored even if the owner is idle.
- On a transfer from requester w:
  - out <= data[w], out_src <= w, out_valid <= 1
  - ptr <= (w == NUM_REQ-1) ? 0 : w+1
  - if lock[w]=1: owner <= w, owner_valid <= 1; else owner_valid <= 0
- Delivery without a new transfer: out_valid <= 0. out and out_src hold their last values.
- Delivery and transfer on the same edge: the new beat replaces the old one and out_valid stays 1. This is the FULL→FULL path.
- Lock release: owner_valid <= 0 when the owner transfers with lock=0, or when req[owner]=0 on any edge.
- out and out_src change only on a transfer edge. They are stable while out_valid=1 and out_ready=0.
- Requester rules: keep data[i] stable while req[i]=1 and grant[i]=0. Deassert req after the transfer edge if no further beats remain.

## Timing
- grant is combinational from req, ptr, owner state, out_valid and out_ready. No combinational path from data to any output.
- Latency: data captured on the transfer edge appears on out with out_valid=1 in the following cycle (1 cycle).
- Throughput: 1 beat per cycle when out_ready is held high.
- Reset values: out=0, out_src=0, out_valid=0, ptr=0, owner_valid=0. grant=0 during any cycle in which reset=1.
- Reset mid-operation discards any pending beat and any lock. Beats offered during the reset cycle are not transferred.
- Backpressure: FULL with out_ready=0 forces grant=0 for that cycle.
- Wrap-around: a grant to NUM_REQ-1 sets ptr=0.

## Test plan
- Reset, then req=4'b0101 held with out_ready=1 → grants alternate 0,2,0,2. Each out_src matches the grant from the previous cycle, and out equals that requester's data.
- All four req high, out_ready=1, data[i]=32'h10+i → out sequence 0x10,0x11,0x12,0x13,0x10, one per cycle. ptr wraps from 3 to 0.
- Beat from requester 1 (0xAA) in FULL, out_ready=0 for 3 cycles with req[2] high → grant=0 and out=0xAA stable for all 3 cycles. Then out_ready=1 → same-edge delivery plus transfer of requester 2, out_valid remains 1.
- Requester 3 transfers with lock=1 while req[0] is high → next grants go only to 3. Requester 3 transfers with lock=0 → the following grant goes to 0.
- Locked owner 1 drops req while req[2]=1 → lock releases, and requester 2 is granted on the next cycle.
- Reset asserted while FULL and locked → out_valid=0, out=0, grant=0. After reset, requester 0 wins first among all-high req.
